// File: rtl/program_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
package program_loader_pkg;

    localparam int unsigned HdrBytes     = 2;
    localparam int unsigned BytesPerWord = 4;
    localparam int unsigned WordW        = 8 * BytesPerWord;
    localparam int unsigned ByteCntW     = $clog2(BytesPerWord);

    typedef enum logic [2:0] {
        StLenHi,
        StLenLo,
        StCheck,
        StData,
        StWrite,
        StDone,
        StErr
    } state_e;

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input and instruction-memory write/status bundle of the program loader.
interface program_loader_if #(
    parameter int unsigned ADDR_W = 10
) ();

    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              start_up;
    logic              load_done;
    logic              load_err;

    modport master (
        output in_data, in_valid,
        input  in_ready, imem_we, imem_addr, imem_wdata, start_up, load_done, load_err
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, imem_we, imem_addr, imem_wdata, start_up, load_done, load_err
    );

endinterface

// File: rtl/program_loader_word_assembler.sv
// Word assembler: shifts bytes in MSB-first and flags the transfer that completes a word.
module program_loader_word_assembler
    import program_loader_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             shift_en_i,
    input  logic             clear_i,
    input  logic [7:0]       byte_i,
    output logic [WordW-1:0] word_o,
    output logic             word_full_o
);

    logic [WordW-1:0]    word_q, word_d;
    logic [ByteCntW-1:0] cnt_q, cnt_d;

    always_comb begin
        word_d = word_q;
        cnt_d  = cnt_q;
        if (clear_i) begin
            word_d = '0;
            cnt_d  = '0;
        end else if (shift_en_i) begin
            word_d = {word_q[WordW-9:0], byte_i};
            cnt_d  = cnt_q + 1'b1;
        end
    end

    // High on the transfer that wraps the byte counter back to zero.
    assign word_full_o = shift_en_i && !clear_i && (cnt_q == ByteCntW'(BytesPerWord - 1));
    assign word_o      = word_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/program_loader.sv
// Program loader: parses a length-prefixed byte stream into instruction-memory writes and
// holds the processor in start-up until the whole program is written.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned LEN_W  = 8 * HdrBytes
) (
    input logic             clk,
    input logic             rst_n,
    program_loader_if.slave bus
);

    localparam int unsigned MaxWords = 2 ** ADDR_W;

    state_e           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] word_cnt_q, word_cnt_d;
    logic             in_ready_q, in_ready_d;
    logic             start_up_q, start_up_d;
    logic             load_done_q, load_done_d;
    logic             load_err_q, load_err_d;
    logic [ADDR_W-1:0] addr_hold_q;
    logic [WordW-1:0]  wdata_hold_q;

    logic             xfer;
    logic             shift_en;
    logic             asm_clear;
    logic             word_full;
    logic [WordW-1:0] asm_word;
    logic             writing;

    assign xfer    = bus.in_valid & in_ready_q;
    assign writing = (state_q == StWrite);

    program_loader_word_assembler u_word_assembler (
        .clk        (clk),
        .rst_n      (rst_n),
        .shift_en_i (shift_en),
        .clear_i    (asm_clear),
        .byte_i     (bus.in_data),
        .word_o     (asm_word),
        .word_full_o(word_full)
    );

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        word_cnt_d = word_cnt_q;
        shift_en   = 1'b0;
        asm_clear  = 1'b0;
        unique case (state_q)
            StLenHi: begin
                if (xfer) begin
                    len_d   = {len_q[LEN_W-9:0], bus.in_data};
                    state_d = StLenLo;
                end
            end
            StLenLo: begin
                if (xfer) begin
                    len_d   = {len_q[LEN_W-9:0], bus.in_data};
                    state_d = StCheck;
                end
            end
            StCheck: begin
                if (len_q == '0 || 32'(len_q) > MaxWords) begin
                    state_d = StErr;
                end else begin
                    word_cnt_d = '0;
                    asm_clear  = 1'b1;
                    state_d    = StData;
                end
            end
            StData: begin
                shift_en = xfer;
                if (word_full) state_d = StWrite;
            end
            StWrite: begin
                word_cnt_d = word_cnt_q + 1'b1;
                state_d    = (word_cnt_d == len_q) ? StDone : StData;
            end
            StDone:  state_d = StDone;
            StErr:   state_d = StErr;
            default: state_d = StErr;
        endcase

        // Status outputs are registered from the next state so they change on the entry edge.
        in_ready_d  = (state_d == StLenHi) || (state_d == StLenLo) || (state_d == StData);
        start_up_d  = (state_d != StDone);
        load_done_d = (state_d == StDone);
        load_err_d  = (state_d == StErr);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StLenHi;
            len_q        <= '0;
            word_cnt_q   <= '0;
            in_ready_q   <= 1'b0;
            start_up_q   <= 1'b1;
            load_done_q  <= 1'b0;
            load_err_q   <= 1'b0;
            addr_hold_q  <= '0;
            wdata_hold_q <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            word_cnt_q  <= word_cnt_d;
            in_ready_q  <= in_ready_d;
            start_up_q  <= start_up_d;
            load_done_q <= load_done_d;
            load_err_q  <= load_err_d;
            if (writing) begin
                addr_hold_q  <= word_cnt_q[ADDR_W-1:0];
                wdata_hold_q <= asm_word;
            end
        end
    end

    // Address/data are live during WRITE and hold the last written values afterwards.
    assign bus.imem_we    = writing;
    assign bus.imem_addr  = writing ? word_cnt_q[ADDR_W-1:0] : addr_hold_q;
    assign bus.imem_wdata = writing ? asm_word : wdata_hold_q;
    assign bus.in_ready   = in_ready_q;
    assign bus.start_up   = start_up_q;
    assign bus.load_done  = load_done_q;
    assign bus.load_err   = load_err_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader: normal, bubbled, error, reset and
// full-capacity loads.
module tb_program_loader;

    localparam int unsigned AW = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    program_loader_if #(.ADDR_W(AW)) bus ();

    program_loader #(.ADDR_W(AW), .LEN_W(16)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;
    int n_timeout = 0;

    // Write monitor, sampled on the falling edge.
    logic [AW-1:0] wr_addr[$];
    logic [31:0]   wr_data[$];
    int            wr_cyc[$];
    int            cyc = 0;
    logic          we_prev = 1'b0;
    logic          su_prev = 1'b1;
    int            we_double = 0;
    int            both_high = 0;
    int            su_fall_cyc = -1;

    always @(negedge clk) begin
        cyc++;
        if (bus.imem_we === 1'b1) begin
            wr_addr.push_back(bus.imem_addr);
            wr_data.push_back(bus.imem_wdata);
            wr_cyc.push_back(cyc);
            if (we_prev) we_double++;
        end
        we_prev = (bus.imem_we === 1'b1);
        if (su_prev && bus.start_up === 1'b0) su_fall_cyc = cyc;
        su_prev = (bus.start_up !== 1'b0);
        if (bus.load_done === 1'b1 && bus.load_err === 1'b1) both_high++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the byte was accepted.
    task automatic send_byte(input logic [7:0] b, input bit bubble);
        bit accepted = 1'b0;
        if (n_timeout != 0) return;
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        for (int g = 0; g < 100 && !accepted; g++) begin
            accepted = (bus.in_ready === 1'b1);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        if (!accepted) begin
            n_timeout++;
            check("xfer_accept", accepted, 1);
        end
        if (bubble) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w, input bit bubble);
        for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8], bubble);
    endtask

    task automatic pulse_reset();
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    int base;
    int bad;
    int rdy_seen;
    int done_low;

    initial begin
        bus.in_data  = 8'h00;
        bus.in_valid = 1'b0;

        // Reset state
        wait_cycles(2);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_imem_we", bus.imem_we, 0);
        check("rst_imem_addr", bus.imem_addr, 0);
        check("rst_imem_wdata", bus.imem_wdata, 0);
        check("rst_start_up", bus.start_up, 1);
        check("rst_load_done", bus.load_done, 0);
        check("rst_load_err", bus.load_err, 0);
        rst_n = 1'b1;
        wait_cycles(1);
        check("idle_in_ready", bus.in_ready, 1);

        // Two words, in_valid held high
        base = wr_addr.size();
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_word(32'h2008_0005, 0);
        send_word(32'h0109_5020, 0);
        wait_cycles(3);
        check("n2_count", wr_addr.size() - base, 2);
        check("n2_addr0", wr_addr[base], 0);
        check("n2_data0", wr_data[base], 32'h2008_0005);
        check("n2_addr1", wr_addr[base+1], 1);
        check("n2_data1", wr_data[base+1], 32'h0109_5020);
        check("n2_word_spacing", wr_cyc[base+1] - wr_cyc[base], 5);
        check("n2_su_fall", su_fall_cyc, wr_cyc[base+1] + 1);
        check("n2_start_up", bus.start_up, 0);
        check("n2_load_done", bus.load_done, 1);
        check("n2_load_err", bus.load_err, 0);
        check("n2_addr_hold", bus.imem_addr, 1);
        check("n2_wdata_hold", bus.imem_wdata, 32'h0109_5020);

        // Input ignored after DONE
        base = wr_addr.size();
        rdy_seen = 0;
        done_low = 0;
        for (int i = 0; i < 20; i++) begin
            bus.in_data  = 8'($urandom);
            bus.in_valid = 1'b1;
            @(negedge clk);
            if (bus.in_ready !== 1'b0) rdy_seen++;
            if (bus.load_done !== 1'b1) done_low++;
        end
        bus.in_valid = 1'b0;
        check("done_in_ready", rdy_seen, 0);
        check("done_no_write", wr_addr.size() - base, 0);
        check("done_stays", done_low, 0);

        // Same stream with bubbles
        pulse_reset();
        check("rst2_start_up", bus.start_up, 1);
        check("rst2_load_done", bus.load_done, 0);
        base = wr_addr.size();
        send_byte(8'h00, 1);
        send_byte(8'h02, 1);
        send_word(32'h2008_0005, 1);
        send_word(32'h0109_5020, 1);
        wait_cycles(3);
        check("bub_count", wr_addr.size() - base, 2);
        check("bub_addr0", wr_addr[base], 0);
        check("bub_data0", wr_data[base], 32'h2008_0005);
        check("bub_addr1", wr_addr[base+1], 1);
        check("bub_data1", wr_data[base+1], 32'h0109_5020);
        check("bub_load_done", bus.load_done, 1);
        check("bub_start_up", bus.start_up, 0);

        // Zero-length header
        pulse_reset();
        base = wr_addr.size();
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        wait_cycles(3);
        check("len0_err", bus.load_err, 1);
        check("len0_start_up", bus.start_up, 1);
        check("len0_in_ready", bus.in_ready, 0);
        check("len0_done", bus.load_done, 0);
        check("len0_no_write", wr_addr.size() - base, 0);

        // Oversized header (1025)
        pulse_reset();
        send_byte(8'h04, 0);
        send_byte(8'h01, 0);
        wait_cycles(3);
        check("len1025_err", bus.load_err, 1);
        check("len1025_in_ready", bus.in_ready, 0);
        check("len1025_no_write", wr_addr.size() - base, 0);

        // Reset in the middle of the first word
        pulse_reset();
        base = wr_addr.size();
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_in_ready", bus.in_ready, 0);
        check("mid_rst_err", bus.load_err, 0);
        rst_n = 1'b1;
        wait_cycles(5);
        check("mid_rst_no_write", wr_addr.size() - base, 0);
        check("mid_rst_start_up", bus.start_up, 1);
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_word(32'hDEAD_BEEF, 0);
        wait_cycles(3);
        check("fresh_count", wr_addr.size() - base, 1);
        check("fresh_addr", wr_addr[base], 0);
        check("fresh_data", wr_data[base], 32'hDEAD_BEEF);
        check("fresh_done", bus.load_done, 1);

        // Full capacity (1024 words)
        pulse_reset();
        base = wr_addr.size();
        send_byte(8'h04, 0);
        send_byte(8'h00, 0);
        for (int i = 0; i < 1024; i++) send_word(32'hC000_0000 | 32'(i), 0);
        wait_cycles(3);
        check("max_count", wr_addr.size() - base, 1024);
        bad = 0;
        for (int i = 0; i < 1024 && base + i < wr_addr.size(); i++) begin
            if (wr_addr[base+i] !== AW'(i) || wr_data[base+i] !== (32'hC000_0000 | 32'(i))) bad++;
        end
        check("max_sequence", bad, 0);
        check("max_last_addr", bus.imem_addr, 10'h3FF);
        check("max_last_data", bus.imem_wdata, 32'hC000_03FF);
        check("max_done", bus.load_done, 1);
        check("max_err", bus.load_err, 0);

        check("we_single_pulse", we_double, 0);
        check("done_err_exclusive", both_high, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Writer-side counterpart to the processor's instruction fetch, which only reads instruction memory.
- Receives a byte stream over a valid/ready handshake, assembles big-endian 32-bit instruction words and writes them into the instruction memory write port.
- Holds the processor's start_up asserted until the whole program is loaded, then releases it.

Parameters:
- ADDR_W, 10, instruction memory word-address width; capacity is 2^ADDR_W words.
- LEN_W, 16, width of the length header (word count) at the start of the stream.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data valid.
- in_ready  out  1  loader accepts a byte this cycle.
- imem_we  out  1  instruction memory write enable, one-cycle pulse.
- imem_addr  out  ADDR_W  word address for the write.
- imem_wdata  out  32  instruction word.
- start_up  out  1  drives the processor start_up input; 1 while loading or in error.
- load_done  out  1  level; program loaded successfully.
- load_err  out  1  level; bad length header.

Behaviour:
- Reset is synchronous: when rst_n is low at a clock edge, the following apply, whatever the current state (including mid-word):
  - state=LEN_HI, in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0;
  - start_up=1, load_done=0, load_err=0;
  - byte count and word count cleared.
  - A partly assembled word is discarded and is never written.
- Stream format: the length header comes first as 2 bytes, MSB then LSB, giving N words. It is followed by N words of 4 bytes each, most significant byte first.
- A byte transfer happens only when in_valid and in_ready are both high at a clock edge. in_data is sampled at that edge. in_valid without in_ready has no effect.
- in_ready is a registered output. It is 1 in LEN_HI, LEN_LO and DATA; it is 0 in all other states and during reset.
- States and transitions:
  - LEN_HI: on transfer, len[15:8] = byte; go to LEN_LO.
  - LEN_LO: on transfer, len[7:0] = byte; go to CHECK.
  - CHECK (1 cycle, no transfer): if len == 0 or len > 2^ADDR_W, go to ERR. Otherwise clear the word counter and go to DATA.
  - DATA: on each transfer, shift the byte into a 32-bit assembly register (new byte enters at bits [7:0]) and increment the 2-bit byte counter. On the transfer where the counter wraps 3 -> 0, go to WRITE.
  - WRITE (1 cycle): imem_we=1, imem_addr = word counter[ADDR_W-1:0], imem_wdata = assembled word. Increment the word counter. If the incremented count == len, go to DONE; otherwise return to DATA.
  - DONE: terminal until reset. start_up=0, load_done=1, in_ready=0. Later in_valid is ignored.
  - ERR: terminal until reset. start_up=1, load_err=1, in_ready=0, no writes.
- Timing and throughput:
  - One word takes at least 5 cycles: 4 transfers plus the WRITE cycle.
  - imem_we goes high in the cycle after the 4th byte's transfer edge.
  - imem_addr and imem_wdata are valid only while imem_we=1 and hold their last value otherwise.
- Output invariants:
  - start_up falls on the same edge that enters DONE, i.e. the cycle after the final write.
  - load_done and load_err are never both 1.
  - Boundary length: len == 2^ADDR_W is legal; the last write goes to address 2^ADDR_W-1 and the word counter does not wrap.
- Gaps in in_valid (bubbles) at any point stall without losing data or state.

Decomposition:
- Shared package holds:
  - state encoding enum (LEN_HI, LEN_LO, CHECK, DATA, WRITE, DONE, ERR);
  - header byte count constant (2);
  - bytes-per-word constant (4).
- One sub-module: word_assembler. It contains the shift register and the 2-bit byte counter, takes shift_en and clear inputs, and outputs word and word_full. The FSM and the counters stay in program_loader.

Test Plan:
- Load N=2 with bytes 00 02 | 20 08 00 05 | 01 09 50 20, in_valid held high:
  - writes addr0=0x20080005, then addr1=0x01095020;
  - each imem_we is a single-cycle pulse;
  - start_up falls the cycle after the second write; load_done=1.
- Same stream with in_valid toggled 1/0 every cycle: identical writes and values, only later; no byte is lost or duplicated.
- Header 00 00: enters ERR; load_err=1, start_up stays 1, in_ready=0, no imem_we.
  - With ADDR_W=10, header 04 01 (1025): ERR.
  - With ADDR_W=10, header 04 00 (1024): legal; after 1024 words the last write is at addr 0x3FF.
- Reset (rst_n low for 1 cycle) after 2 bytes of the first word:
  - no write occurs and start_up=1;
  - a fresh stream 00 01 | DE AD BE EF then writes addr0=0xDEADBEEF.
- After DONE, drive in_valid=1 with arbitrary bytes for 20 cycles: in_ready stays 0, no imem_we, load_done stays 1.
